// File: rtl/axi_lite_master.sv
// axi_lite_master
//   Single-outstanding AXI4-Lite master. A command (read or write of one
//   32-bit word) is accepted on the cmd_* channel, executed on the M_AXI_*
//   channels, and its result is returned on the rsp_* channel.
//
//   Optional feature macro: AXI_MASTER_TIMEOUT_EN
//     defined   - watchdog aborts a transaction after TIMEOUT_CYCLES cycles
//                 in any single wait state (rsp_timeout = 1, rsp_resp = 2'b11)
//     undefined - no watchdog, rsp_timeout tied low
//
//   Ports
//     M_AXI_ACLK, M_AXI_ARESETN : clock, async active-low reset
//     cmd_valid/ready/write/addr/wdata/wstrb : command request channel
//     rsp_valid/ready/write/rdata/resp/timeout : response channel
//     busy : high whenever the FSM is not IDLE
//     M_AXI_AW*/W*/B*/AR*/R* : AXI4-Lite master channels
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   IDLE         | cmd_ready high, waiting for a command
//   WR_ADDR_DATA | AWVALID/WVALID raised, each drops on its own handshake
//   WR_RESP      | BREADY high, waiting for BVALID
//   RD_ADDR      | ARVALID high, waiting for ARREADY
//   RD_DATA      | RREADY high, waiting for RVALID
//   RESP         | rsp_valid high, waiting for rsp_ready
`timescale 1ns/1ps

module axi_lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 9,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    // Word alignment: the two byte-offset bits never reach the bus.
    localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(3));

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [DW/8-1:0]     r_wstrb;
    logic                r_write;
    logic                r_cmd_ready;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_rsp_valid;
    logic                r_rsp_write;
    logic [DW-1:0]       r_rsp_rdata;
    logic [1:0]          r_rsp_resp;
    logic                r_rsp_timeout;

    // A channel counts as done once its VALID has dropped or is handshaking now.
    logic w_aw_done;
    logic w_w_done;
    assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int            CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             w_in_wait;
    logic             w_leave;
    logic             w_wd_fire;

    assign w_in_wait = (r_state == WR_ADDR_DATA) || (r_state == WR_RESP) ||
                       (r_state == RD_ADDR)      || (r_state == RD_DATA);
    // Any state change out of a wait state restarts the count for the next one.
    assign w_leave   = ((r_state == WR_ADDR_DATA) && w_aw_done && w_w_done) ||
                       ((r_state == WR_RESP) && M_AXI_BVALID) ||
                       ((r_state == RD_ADDR) && M_AXI_ARREADY) ||
                       ((r_state == RD_DATA) && M_AXI_RVALID);
    assign w_wd_fire = w_in_wait && (r_wd_cnt == WD_LAST);
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_write       <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            r_wd_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr & ALIGN_MASK;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        r_write     <= cmd_write;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_ADDR_DATA;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_write   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= M_AXI_BRESP;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= RESP;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_write   <= 1'b0;
                        r_rsp_rdata   <= M_AXI_RDATA;
                        r_rsp_resp    <= M_AXI_RRESP;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    // cmd_ready rises the cycle after the response handshake.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

`ifdef AXI_MASTER_TIMEOUT_EN
            r_wd_cnt <= (w_in_wait && !w_leave) ? r_wd_cnt + 1'b1 : '0;
            // Abort overrides whatever the wait state decided this cycle.
            if (w_wd_fire) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_write   <= r_write;
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= 2'b11;
                r_rsp_timeout <= 1'b1;
                r_wd_cnt      <= '0;
                r_state       <= RESP;
            end
`endif
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = (r_state != IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
`ifdef AXI_MASTER_TIMEOUT_EN
    assign rsp_timeout   = r_rsp_timeout;
`else
    assign rsp_timeout   = 1'b0;
`endif

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

`ifndef AXI_MASTER_TIMEOUT_EN
    // Without the watchdog the abort flag register has no reader.
    logic w_unused;
    assign w_unused = r_rsp_timeout;
`endif

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite master that turns single-word register-access commands into AXI4-Lite read and write transactions. It is the initiator side of the same protocol our configuration-register slave answers, and it serves two purposes. In the testbench it drives the register file. In the fabric it lets local sequencers (training loaders, characterization scripts) program remote register banks without a processor. It runs one transaction at a time, returns the response on a valid/ready channel, and optionally aborts on a hung slave.

## Interface
- C_M_AXI_ADDR_WIDTH, 9: AXI address width in bits.
- C_M_AXI_DATA_WIDTH, 32: AXI data width in bits; only 32 is supported.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles. Used only when AXI_MASTER_TIMEOUT_EN is defined.
- M_AXI_ACLK  in  1  sole clock; every register updates on its rising edge.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address; bits [1:0] are forced to 0 on the bus.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echoes cmd_write of the completed command.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- rsp_timeout  out  1  transaction was aborted by the watchdog.
- busy  out  1  high in every state except IDLE.
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels. AWPROT and ARPROT are tied to 3'b000.

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- **IDLE**
  - cmd_ready = 1.
  - On command acceptance, latch addr, wdata, wstrb and write.
  - Go to WR_ADDR_DATA if write, else RD_ADDR.
- **WR_ADDR_DATA**
  - AWVALID and WVALID both assert on entry.
  - Each drops independently on its own handshake; either may complete first or both in the same cycle.
  - Go to WR_RESP once both handshakes are done.
- **WR_RESP**
  - BREADY = 1.
  - On BVALID, capture BRESP, set rsp_rdata = 0, go to RESP.
- **RD_ADDR**
  - ARVALID = 1 until ARREADY, then go to RD_DATA.
- **RD_DATA**
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP, go to RESP.
- **RESP**
  - rsp_valid = 1 until rsp_ready, then go to IDLE.
  - A new command cannot be accepted in the same cycle as rsp_ready; cmd_ready asserts the following cycle.
- **Bus stability:** AWADDR, WDATA, WSTRB and ARADDR are driven from the latched registers, so they stay stable while the matching VALID is high.
- **VALID rule:** no VALID is withdrawn before its handshake, except on a watchdog abort.
- **Unused response fields:** RESP values other than OKAY are passed through unchanged; the block does not treat them as errors.

## Timing
- **Reset values:** all VALID/READY outputs 0, cmd_ready 0 while reset is asserted, rsp_* 0, busy 0, state IDLE.
- **After reset:** cmd_ready goes high on the first clock after deassertion.
- **Latency:** command accepted at cycle T → AW/W/AR VALID at T+1 → BREADY/RREADY at the cycle after the address handshake → rsp_valid at the cycle after the B/R handshake.
- **Minimum write latency:** T+3 with a zero-wait slave that asserts BVALID at T+2.
- **Minimum read latency:** T+3.
- **Mid-transaction reset:** asynchronous; all outputs return to their reset values immediately and the in-flight transaction is dropped. The connected slave must be reset together with the master.

## Configuration
- Macro: AXI_MASTER_TIMEOUT_EN.
- **Defined**
  - A counter clears on entry to WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA, and increments each cycle spent in those states.
  - When it reaches TIMEOUT_CYCLES, all VALID/READY outputs drop and the state goes to RESP with rsp_timeout = 1, rsp_resp = 2'b11, rsp_rdata = 0.
  - This abort is a recovery action for a hung slave; the interconnect must be reset afterwards.
- **Undefined**
  - No counter is built, rsp_timeout is tied to 0, and the master waits indefinitely.

## Test plan
- **Write, zero-wait slave:** write 0x0000_00A5 to 0x010, wstrb 4'hF → one AW and one W handshake at T+1, rsp_valid at T+3 with rsp_write = 1, rsp_resp = 0, and slave register 0x010 = 0xA5.
- **Read with 3-cycle ARREADY delay:** read 0x010 → ARVALID held stable for 4 cycles, rsp_rdata = 0x0000_00A5, rsp_resp = 0.
- **WREADY before AWREADY:** slave asserts WREADY 2 cycles before AWREADY → WVALID drops after its handshake, AWVALID stays high, exactly one B handshake, one response.
- **Response back-pressure:** rsp_ready held low for 5 cycles with cmd_valid high → cmd_ready stays 0, rsp fields stable; the next command is accepted one cycle after rsp_ready.
- **Watchdog (macro defined, TIMEOUT_CYCLES = 16):** slave never asserts BVALID → at the 16th wait cycle rsp_timeout = 1, rsp_resp = 2'b11, BREADY = 0.
- **Reset mid-read:** M_AXI_ARESETN pulsed low while ARVALID = 1 → ARVALID = 0 immediately, busy = 0, and a fresh read after release completes normally.
